// File: rtl/bus_pkg.sv
// bus_pkg: shared source codes, destination indices, FSM states and micro-op layout
// used by the bus sequencer and by every data_bus user.
package bus_pkg;

    localparam int SELECTOR_WIDTH = 4;
    localparam int DEST_COUNT     = 11;

    localparam logic [SELECTOR_WIDTH-1:0] SRC_ZERO   = 4'd0;
    localparam logic [SELECTOR_WIDTH-1:0] SRC_PC     = 4'd1;
    localparam logic [SELECTOR_WIDTH-1:0] SRC_SP     = 4'd2;
    localparam logic [SELECTOR_WIDTH-1:0] SRC_ADD    = 4'd3;
    localparam logic [SELECTOR_WIDTH-1:0] SRC_X      = 4'd4;
    localparam logic [SELECTOR_WIDTH-1:0] SRC_Y      = 4'd5;
    localparam logic [SELECTOR_WIDTH-1:0] SRC_STAT   = 4'd6;
    localparam logic [SELECTOR_WIDTH-1:0] SRC_MEM    = 4'd7;
    localparam logic [SELECTOR_WIDTH-1:0] SRC_IMM    = 4'd8;
    localparam logic [SELECTOR_WIDTH-1:0] SRC_FETCH  = 4'd9;
    localparam logic [SELECTOR_WIDTH-1:0] SRC_DECODE = 4'd10;
    localparam logic [SELECTOR_WIDTH-1:0] SRC_ALU    = 4'd11;
    localparam logic [SELECTOR_WIDTH-1:0] SRC_CONST1 = 4'd12;

    localparam int DEST_PC     = 0;
    localparam int DEST_SP     = 1;
    localparam int DEST_ADD    = 2;
    localparam int DEST_X      = 3;
    localparam int DEST_Y      = 4;
    localparam int DEST_STAT   = 5;
    localparam int DEST_MEM    = 6;
    localparam int DEST_FETCH  = 7;
    localparam int DEST_DECODE = 8;
    localparam int DEST_ALU0   = 9;
    localparam int DEST_ALU1   = 10;

    typedef enum logic [1:0] {IDLE, DRIVE, CAPTURE} state_e;

    typedef struct packed {
        logic                      last;
        logic [DEST_COUNT-1:0]     dest;
        logic [SELECTOR_WIDTH-1:0] src;
    } uop_t;

    // A micro-op needs at least one destination and a defined source code.
    function automatic logic uop_ok(input uop_t u);
        return (u.dest != '0) && (u.src <= SRC_CONST1);
    endfunction

endpackage

// File: rtl/uop_fifo.sv
// uop_fifo: small synchronous FIFO with flush; a push is refused when full even if
// a pop happens in the same cycle.
module uop_fifo #(
    parameter int WIDTH = 16,
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             push,
    input  logic             pop,
    input  logic             flush,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] dout,
    output logic             full,
    output logic             empty
);

    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [WIDTH-1:0] mem_d [DEPTH];
    logic [AW:0]      wr_q, wr_d, rd_q, rd_d;

    assign empty = wr_q == rd_q;
    assign full  = (wr_q[AW] != rd_q[AW]) && (wr_q[AW-1:0] == rd_q[AW-1:0]);
    assign dout  = mem_q[rd_q[AW-1:0]];

    always_comb begin
        mem_d = mem_q;
        wr_d  = wr_q;
        rd_d  = rd_q;
        if (flush) begin
            wr_d = '0;
            rd_d = '0;
        end else begin
            if (push && !full) begin
                mem_d[wr_q[AW-1:0]] = din;
                wr_d = wr_q + (AW+1)'(1);
            end
            if (pop && !empty)
                rd_d = rd_q + (AW+1)'(1);
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            mem_q <= '{default: '0};
            wr_q  <= '0;
            rd_q  <= '0;
        end else begin
            mem_q <= mem_d;
            wr_q  <= wr_d;
            rd_q  <= rd_d;
        end
    end

endmodule

// File: rtl/bus_sequencer.sv
// bus_sequencer: queues register-transfer micro-ops and sequences them onto the data bus,
// driving destination selectors one cycle before pulsing the matching load enables.
module bus_sequencer #(
    parameter int SELECTOR_WIDTH = 4,
    parameter int DEST_COUNT     = 11,
    parameter int FIFO_DEPTH     = 4
) (
    input  logic                                 clk,
    input  logic                                 reset_n,
    input  logic                                 uop_valid,
    output logic                                 uop_ready,
    input  logic [SELECTOR_WIDTH-1:0]            uop_src,
    input  logic [DEST_COUNT-1:0]                uop_dest,
    input  logic                                 uop_last,
    input  logic                                 flush,
    output logic [DEST_COUNT*SELECTOR_WIDTH-1:0] sel_out,
    output logic [DEST_COUNT-1:0]                load_en,
    output logic                                 busy,
    output logic                                 group_done,
    output logic                                 uop_err
);

    import bus_pkg::*;

    uop_t   head, cur_q, cur_d;
    state_e state_q, state_d;
    logic   full, empty, pop;

    logic [DEST_COUNT*SELECTOR_WIDTH-1:0] sel_q, sel_d;
    logic [DEST_COUNT-1:0]                load_en_q, load_en_d;
    logic                                 busy_q, busy_d;
    logic                                 group_done_q, group_done_d;
    logic                                 uop_err_q, uop_err_d;

    assign uop_ready  = !full && !flush;
    assign sel_out    = sel_q;
    assign load_en    = load_en_q;
    assign busy       = busy_q;
    assign group_done = group_done_q;
    assign uop_err    = uop_err_q;

    uop_fifo #(
        .WIDTH($bits(uop_t)),
        .DEPTH(FIFO_DEPTH)
    ) u_fifo (
        .clk    (clk),
        .reset_n(reset_n),
        .push   (uop_valid && uop_ready),
        .pop    (pop),
        .flush  (flush),
        .din    ({uop_last, uop_dest, uop_src}),
        .dout   (head),
        .full   (full),
        .empty  (empty)
    );

    // Outputs are registered from the current state, so each state's bus effect
    // becomes visible at the edge that leaves it.
    always_comb begin
        pop          = !flush && !empty && (state_q != DRIVE);
        cur_d        = cur_q;
        state_d      = IDLE;
        sel_d        = '0;
        load_en_d    = (state_q == CAPTURE) ? cur_q.dest : '0;
        group_done_d = (state_q == CAPTURE) && cur_q.last;
        uop_err_d    = pop && !uop_ok(head);
        busy_d       = !empty || (state_q != IDLE);
        for (int i = 0; i < DEST_COUNT; i++)
            sel_d[i*SELECTOR_WIDTH +: SELECTOR_WIDTH] =
                (state_q != IDLE && cur_q.dest[i]) ? cur_q.src : '0;
        if (state_q == DRIVE)
            state_d = CAPTURE;
        else if (pop && uop_ok(head)) begin
            cur_d   = head;
            state_d = DRIVE;
        end
        if (flush) begin
            state_d      = IDLE;
            sel_d        = '0;
            load_en_d    = '0;
            group_done_d = 1'b0;
            uop_err_d    = 1'b0;
            busy_d       = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q      <= IDLE;
            cur_q        <= '0;
            sel_q        <= '0;
            load_en_q    <= '0;
            group_done_q <= 1'b0;
            uop_err_q    <= 1'b0;
            busy_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            cur_q        <= cur_d;
            sel_q        <= sel_d;
            load_en_q    <= load_en_d;
            group_done_q <= group_done_d;
            uop_err_q    <= uop_err_d;
            busy_q       <= busy_d;
        end
    end

endmodule

// File: tb/tb_bus_sequencer.sv
// tb_bus_sequencer: directed micro-op sequences; expected transfers are queued at push
// time and a negedge monitor matches every load_en pulse against the queue head.
module tb_bus_sequencer;

    logic        clk = 1'b0, reset_n = 1'b0;
    logic        uop_valid = 1'b0, uop_last = 1'b0, flush = 1'b0;
    logic [3:0]  uop_src = '0;
    logic [10:0] uop_dest = '0;
    logic        uop_ready, busy, group_done, uop_err;
    logic [43:0] sel_out;
    logic [10:0] load_en;

    typedef struct packed {
        logic [10:0] dest;
        logic [43:0] sel;
        logic        last;
    } exp_t;

    exp_t xfer_q[$];
    exp_t e;
    int   checks = 0, errors = 0, err_exp = 0, err_seen = 0, cyc = 0, last_cyc = -1;
    logic check_gap = 1'b0, saw_full = 1'b0;

    bus_sequencer dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .uop_valid (uop_valid),
        .uop_ready (uop_ready),
        .uop_src   (uop_src),
        .uop_dest  (uop_dest),
        .uop_last  (uop_last),
        .flush     (flush),
        .sel_out   (sel_out),
        .load_en   (load_en),
        .busy      (busy),
        .group_done(group_done),
        .uop_err   (uop_err)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc++;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got=%0h want=%0h t=%0t", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Scoreboard monitor: every load_en pulse must match the oldest expected transfer.
    always @(negedge clk) begin
        if (!check_gap) last_cyc = -1;
        if (reset_n && load_en != '0) begin
            if (xfer_q.size() == 0)
                chk("unexpected_load", 64'(load_en), 64'd0);
            else begin
                e = xfer_q.pop_front();
                chk("xfer_load", 64'(load_en), 64'(e.dest));
                chk("xfer_sel", 64'(sel_out), 64'(e.sel));
                chk("xfer_last", 64'(group_done), 64'(e.last));
            end
            if (check_gap && last_cyc >= 0) chk("xfer_gap", 64'(cyc - last_cyc), 64'd2);
            last_cyc = cyc;
        end
        if (reset_n && group_done && load_en == '0) chk("stray_group_done", 64'(group_done), 64'd0);
        if (reset_n && uop_err) err_seen++;
    end

    task automatic push(input logic [3:0] s, input logic [10:0] d, input logic l,
                        input logic [43:0] sel, input logic track);
        int   n = 0;
        logic hs = 1'b0;
        uop_valid = 1'b1;
        uop_src   = s;
        uop_dest  = d;
        uop_last  = l;
        while (!hs && n < 50) begin
            @(negedge clk);
            hs = uop_ready;
            if (!hs) saw_full = 1'b1;
            @(posedge clk);
            #1;
            n++;
        end
        uop_valid = 1'b0;
        chk("push_handshake", 64'(hs), 64'd1);
        if (hs && track) begin
            if (d == '0 || s > 4'd12) err_exp++;
            else xfer_q.push_back({d, sel, l});
        end
    endtask

    task automatic wait_idle();
        int n = 0;
        repeat (2) tick();
        while (busy && n < 100) begin
            tick();
            n++;
        end
        chk("idle_reached", 64'(busy), 64'd0);
        tick();
    endtask

    initial begin
        repeat (3) tick();
        chk("rst_sel", 64'(sel_out), 64'd0);
        chk("rst_load", 64'(load_en), 64'd0);
        chk("rst_busy", 64'(busy), 64'd0);
        chk("rst_gdone", 64'(group_done), 64'd0);
        chk("rst_err", 64'(uop_err), 64'd0);
        reset_n = 1'b1;
        #1 chk("rst_ready", 64'(uop_ready), 64'd1);
        tick();

        // single transfer x -> sp, checked cycle by cycle from the push edge
        push(4'd4, 11'h002, 1'b1, 44'h00000000040, 1'b1);
        tick();
        chk("single_busy_n1", 64'(busy), 64'd1);
        chk("single_sel_n1", 64'(sel_out), 64'd0);
        tick();
        chk("single_sel_n2", 64'(sel_out), 64'h40);
        chk("single_load_n2", 64'(load_en), 64'd0);
        tick();
        chk("single_load_n3", 64'(load_en), 64'h002);
        chk("single_gdone_n3", 64'(group_done), 64'd1);
        tick();
        chk("single_busy_n4", 64'(busy), 64'd0);
        chk("single_load_n4", 64'(load_en), 64'd0);
        chk("single_sel_n4", 64'(sel_out), 64'd0);

        // broadcast alu -> add, x
        push(4'd11, 11'h00C, 1'b0, 44'h0000000BB00, 1'b1);
        repeat (3) tick();
        chk("bcast_load", 64'(load_en), 64'h00C);
        chk("bcast_sel", 64'(sel_out), 64'hBB00);
        tick();
        chk("bcast_load_once", 64'(load_en), 64'd0);
        wait_idle();

        // back-pressure burst: pushes outpace the 2-cycle transfer rate until full
        check_gap = 1'b1;
        saw_full  = 1'b0;
        push(4'd1,  11'h400, 1'b0, 44'h10000000000, 1'b1);
        push(4'd2,  11'h081, 1'b0, 44'h00020000002, 1'b1);
        push(4'd12, 11'h010, 1'b0, 44'h000000C0000, 1'b1);
        push(4'd0,  11'h7FF, 1'b0, 44'h00000000000, 1'b1);
        push(4'd7,  11'h040, 1'b1, 44'h00007000000, 1'b1);
        push(4'd4,  11'h002, 1'b0, 44'h00000000040, 1'b1);
        push(4'd11, 11'h00C, 1'b0, 44'h0000000BB00, 1'b1);
        push(4'd1,  11'h400, 1'b1, 44'h10000000000, 1'b1);
        wait_idle();
        check_gap = 1'b0;
        chk("backpressure_full", 64'(saw_full), 64'd1);

        // flush during the first CAPTURE: nothing queued may ever load
        push(4'd1,  11'h400, 1'b0, 44'h10000000000, 1'b0);
        push(4'd2,  11'h081, 1'b0, 44'h00020000002, 1'b0);
        push(4'd12, 11'h010, 1'b1, 44'h000000C0000, 1'b0);
        flush = 1'b1;
        #1 chk("flush_ready", 64'(uop_ready), 64'd0);
        tick();
        chk("flush_load", 64'(load_en), 64'd0);
        chk("flush_gdone", 64'(group_done), 64'd0);
        chk("flush_busy", 64'(busy), 64'd0);
        flush = 1'b0;
        for (int i = 0; i < 6; i++) begin
            tick();
            chk("post_flush_load", 64'(load_en), 64'd0);
            chk("post_flush_busy", 64'(busy), 64'd0);
        end

        // invalid micro-ops between valid neighbours
        push(4'd5,  11'h001, 1'b0, 44'h00000000005, 1'b1);
        push(4'd3,  11'h000, 1'b0, 44'h00000000000, 1'b1);
        push(4'd13, 11'h001, 1'b0, 44'h00000000000, 1'b1);
        push(4'd8,  11'h100, 1'b1, 44'h00800000000, 1'b1);
        wait_idle();
        chk("err_count", 64'(err_seen), 64'd2);

        // reset asserted mid-CAPTURE aborts the transfer immediately
        push(4'd4, 11'h002, 1'b1, 44'h00000000040, 1'b0);
        repeat (2) tick();
        chk("pre_reset_sel", 64'(sel_out), 64'h40);
        reset_n = 1'b0;
        #1;
        chk("async_rst_sel", 64'(sel_out), 64'd0);
        chk("async_rst_load", 64'(load_en), 64'd0);
        chk("async_rst_busy", 64'(busy), 64'd0);
        repeat (2) tick();
        reset_n = 1'b1;
        #1 chk("rel_ready", 64'(uop_ready), 64'd1);
        for (int i = 0; i < 4; i++) begin
            tick();
            chk("post_rst_load", 64'(load_en), 64'd0);
        end

        chk("sb_drained", 64'(xfer_q.size()), 64'd0);
        chk("err_total", 64'(err_seen), 64'(err_exp));
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
